// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access-width codes,
// FSM states and the byte-lane count of a data word.
package lsu_pkg;

  localparam int LANES = 4;

  // Access codes are {is_store, funct3} so that loads and stores with the
  // same funct3 (LB/SB, LH/SH, LW/SW) stay distinct enum members.
  typedef enum logic [3:0] {
    LB  = 4'b0000,
    LH  = 4'b0001,
    LW  = 4'b0010,
    LBU = 4'b0100,
    LHU = 4'b0101,
    SB  = 4'b1000,
    SH  = 4'b1001,
    SW  = 4'b1010
  } mem_width_t;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/data_ram.sv
// Word-wide single-port data RAM with per-byte write enables and a
// registered (synchronous) read port.
module data_ram
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [LANES-1:0]      be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic [WORD_WIDTH-1:0] rdata_o
);

  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array and its read register get no reset so the storage maps
  // onto plain RAM macros; resetting them would force a flop array.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int lane = 0; lane < LANES; lane++) begin
        if (be_i[lane]) mem[addr_i][lane*8 +: 8] <= wdata_i[lane*8 +: 8];
      end
    end
    if (re_i) rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: RV32I byte/halfword/word loads and stores against an
// internal synchronous-read RAM; loads take two cycles and stall the front end.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  valid_o,
  output logic                  stall_o,
  output logic                  access_err_o
);

  localparam int WORD_ADDR_WIDTH = MEM_ADDR_WIDTH - 2;

  lsu_state_t            state, state_next;
  logic [1:0]            offset_q;
  logic [2:0]            funct3_q;
  logic [3:0]            op_code;
  logic                  req, is_store, funct_ok, aligned, err;
  logic                  issue_load, do_store;
  logic [LANES-1:0]      be;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata, shifted, load_value;

  // Upper address bits wrap away; collected here only to mark them as unused.
  logic unused_addr;
  assign unused_addr = ^addr_i[DATA_WIDTH-1:MEM_ADDR_WIDTH];

  // NOTE: every signal written in always_comb is given a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_store = mem_write_i && !mem_read_i;  // a load wins over a simultaneous store
    op_code  = {is_store, funct3_i};
    req      = (mem_read_i || mem_write_i) && (state == IDLE);
    funct_ok = op_code inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
    unique case (funct3_i[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !addr_i[0];
      2'b10:   aligned = (addr_i[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    err        = req && !(funct_ok && aligned);
    issue_load = req && !is_store && !err && !rst_i;
    do_store   = req && is_store && !err && !rst_i;
  end

  // Store lanes: replicate the low bits across the word and enable only the
  // addressed lanes.
  always_comb begin
    be        = '1;
    ram_wdata = wdata_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_i[1:0];
        ram_wdata = {LANES{wdata_i[7:0]}};
      end
      2'b01: begin
        be        = addr_i[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  data_ram #(
    .ADDR_WIDTH (WORD_ADDR_WIDTH),
    .WORD_WIDTH (DATA_WIDTH)
  ) u_data_ram (
    .clk_i   (clk_i),
    .re_i    (issue_load),
    .we_i    (do_store),
    .be_i    (be),
    .addr_i  (addr_i[MEM_ADDR_WIDTH-1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      offset_q <= '0;
      funct3_q <= '0;
    end else if (issue_load) begin
      offset_q <= addr_i[1:0];
      funct3_q <= funct3_i;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (issue_load) state_next = LOAD_WAIT;
      LOAD_WAIT: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    shifted = ram_rdata >> {offset_q, 3'b000};
    unique case ({1'b0, funct3_q})
      LB:      load_value = {{24{shifted[7]}}, shifted[7:0]};
      LH:      load_value = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     load_value = {24'b0, shifted[7:0]};
      LHU:     load_value = {16'b0, shifted[15:0]};
      default: load_value = shifted;
    endcase
  end

  // A reset landing in LOAD_WAIT suppresses delivery of the pending load.
  always_comb begin
    stall_o      = issue_load;
    access_err_o = err;
    valid_o      = (state == LOAD_WAIT) && !rst_i;
    rdata_o      = valid_o ? load_value : '0;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory stage of the single-cycle core, directly downstream of the register-file/ALU datapath. It takes the ALU result as a byte address and the rs2 value as store data, performs RV32I byte, halfword and word loads and stores against an internal synchronous-read RAM, and returns the sign- or zero-extended load value to the register write-back mux. The RAM read is synchronous, so every load takes two cycles; `stall_o` holds the PC and instruction for the extra cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath width; only 32 is supported.
- `MEM_ADDR_WIDTH`, 12, byte-address bits decoded (4 KiB RAM); upper address bits are ignored.

Ports:
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `mem_read_i` input 1: load request.
- `mem_write_i` input 1: store request.
- `funct3_i` input 3: access width and sign (RV32I load/store funct3).
- `addr_i` input DATA_WIDTH: byte address (ALU output).
- `wdata_i` input DATA_WIDTH: store data (rs2 value); low bits are used for SB/SH.
- `rdata_o` output DATA_WIDTH: extended load result, to the write-back mux.
- `valid_o` output 1: `rdata_o` holds load data this cycle.
- `stall_o` output 1: hold PC/instruction this cycle.
- `access_err_o` output 1: misaligned access or illegal funct3 this cycle.

## Operation
- **funct3 encodings:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal for the active request type.
- **Alignment:** halfword requires `addr_i[0]=0`. Word requires `addr_i[1:0]=00`. Byte is always aligned.
- **`access_err_o`:** combinational. Asserted when (`mem_read_i` or `mem_write_i`) and (misaligned or illegal funct3) while in IDLE. An erroring request issues no RAM write, no read and no stall.
- **FSM states:** IDLE and LOAD_WAIT.
  - IDLE + legal load: issue RAM read of word `addr_i[MEM_ADDR_WIDTH-1:2]`; register `addr_i[1:0]` and funct3; assert `stall_o`; go to LOAD_WAIT.
  - IDLE + legal store: write on this edge with byte enables. SB uses lane `addr_i[1:0]`, SH uses lanes {`addr_i[1]`*2, +1}, SW uses all four lanes. No stall; stay IDLE.
  - IDLE + both `mem_read_i` and `mem_write_i`: the load wins and the write is dropped.
  - LOAD_WAIT: select the lane using the registered offset; sign-extend (LB/LH) or zero-extend (LBU/LHU); drive `rdata_o`; `valid_o`=1; `stall_o`=0. Inputs are ignored (the same instruction is still presented and must not re-issue). Unconditionally go to IDLE.
- **`rdata_o` outside LOAD_WAIT:** 0.
- **Address wrap:** addresses wrap modulo 2^MEM_ADDR_WIDTH.
- **RAM contents:** not reset.

## Timing
- **Reset values:** state=IDLE, `rdata_o`=0, `valid_o`=0, `stall_o`=0. `access_err_o` is 0 while requests are low.
- **Reset mid-load:** `rst_i` in LOAD_WAIT returns to IDLE next edge; `valid_o`=0 and no data is delivered. Reset has priority over any store in the same cycle (no write).
- **Load latency:** request cycle N (`stall_o`=1), data cycle N+1 (`valid_o`=1). The register file captures on the N+1 → N+2 edge.
- **Store latency:** store visible to a load issued the following cycle.
- **Back-to-back loads:** the next load may issue in the cycle after LOAD_WAIT, i.e. a 2-cycle throughput per load.
- **Output timing:** `stall_o` and `access_err_o` are combinational from inputs/state. `rdata_o` is combinational from the RAM output register and registered offset/funct3.

## Structure
- **Package `lsu_pkg`:**
  - `mem_width_t` enum (LB/LH/LW/LBU/LHU/SB/SH/SW funct3 values).
  - `lsu_state_t` enum (IDLE, LOAD_WAIT).
  - Byte-lane count constant (4).
- **Sub-module `data_ram`:**
  - Word-wide, 4 byte-enable, single-port, synchronous read/write.
  - Depth 2^(MEM_ADDR_WIDTH-2).
  - Write-first is not required (read and write never coincide).
- **Top level:** FSM, alignment/legality check, byte-enable generation, store-data lane replication, and load extraction/extension.

## Test plan
- SW 0x8000_00F1 at 0x100, then LW 0x100 → cycle 1 `stall_o`=1; cycle 2 `valid_o`=1, `rdata_o`=0x8000_00F1, `stall_o`=0.
- After that store: LB 0x100 → 0xFFFF_FFF1; LBU 0x100 → 0x0000_00F1; LH 0x102 → 0xFFFF_8000; LHU 0x102 → 0x0000_8000.
- SB 0xAB at 0x201 over existing word 0x1111_1111 → LW 0x200 returns 0x1111_AB11; SH 0xCDEF at 0x202 → 0xCDEF_AB11.
- LW 0x101, SH 0x203 and funct3=011 load → `access_err_o`=1, `stall_o`=0, memory unchanged, `valid_o` never asserts.
- `rst_i` asserted in the LOAD_WAIT cycle → `valid_o`=0 that edge onward, state IDLE; a subsequent LW completes normally in 2 cycles.
- Address wrap: SW 0xDEAD_BEEF at 0x1000 (MEM_ADDR_WIDTH=12) → LW 0x0 returns 0xDEAD_BEEF.
